// File: rtl/chdr_16sc_tx_deframer_if.sv
// CHDR line input stream and sc16 sample output stream with per-packet sideband,
// bundled for the TX deframer (slave = deframer, master = upstream/downstream driver).
interface chdr_16sc_tx_deframer_if;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_sof;
  logic        o_has_time;
  logic [63:0] o_time;
  logic        o_eob;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_has_time, o_time, o_eob
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_has_time, o_time, o_eob
  );
endinterface

// File: rtl/chdr_16sc_tx_deframer.sv
// Strips CHDR header/timestamp from 64-bit sc16 packets and emits one sample per beat,
// with latched packet metadata and sequence/length error reporting.
module chdr_16sc_tx_deframer #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  chdr_16sc_tx_deframer_if.slave         strm,
  output logic                           eob_empty,
  output logic                           seq_err,
  output logic                           len_err,
  output logic [15:0]                    err_count
);

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_TIME,
    ST_FIRST,
    ST_SECOND,
    ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        has_time_q, has_time_d;
  logic        eob_q, eob_d;
  logic [63:0] time_q, time_d;
  logic        sof_q, sof_d;
  logic [11:0] seq_exp_q, seq_exp_d;
  logic        seq_valid_q, seq_valid_d;
  logic        seq_err_q, seq_err_d;
  logic        len_err_q, len_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        check_en_q, check_en_d;
  logic        eob_empty_q, eob_empty_d;

  logic        in_rdy, out_vld, out_last;
  logic [31:0] out_data;
  logic        in_hs, out_hs;
  logic        seq_evt, len_evt, ctrl_wr, clr;
  logic [15:0] hdr_len, hdr_bytes, hdr_rem;
  logic [11:0] hdr_seq;
  logic        unused_set_data;

  assign unused_set_data = ^set_data[31:2];

  assign hdr_len   = strm.i_tdata[47:32];
  assign hdr_seq   = strm.i_tdata[59:48];
  assign hdr_bytes = strm.i_tdata[61] ? 16'd16 : 16'd8;
  assign hdr_rem   = (hdr_len >= hdr_bytes) ? ((hdr_len - hdr_bytes) >> 2) : 16'd0;

  // A tlast line seen in FIRST while more samples are claimed still holds a valid
  // lower sample, so it is forwarded and SECOND closes the packet as truncated.
  always_comb begin
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    out_data = strm.i_tdata[63:32];
    unique case (state_q)
      ST_HEADER, ST_TIME, ST_DRAIN: in_rdy = 1'b1;
      ST_FIRST: begin
        out_vld  = strm.i_tvalid;
        out_last = (rem_q == 16'd1);
        in_rdy   = (rem_q == 16'd1) ? strm.o_tready : 1'b0;
      end
      ST_SECOND: begin
        out_data = strm.i_tdata[31:0];
        out_vld  = strm.i_tvalid;
        out_last = (rem_q == 16'd1) || strm.i_tlast;
        in_rdy   = strm.o_tready;
      end
      default: in_rdy = 1'b1;
    endcase
  end

  assign in_hs  = strm.i_tvalid && in_rdy;
  assign out_hs = out_vld && strm.o_tready;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    has_time_d  = has_time_q;
    eob_d       = eob_q;
    time_d      = time_q;
    sof_d       = sof_q;
    seq_exp_d   = seq_exp_q;
    seq_valid_d = seq_valid_q;
    eob_empty_d = 1'b0;
    seq_evt     = 1'b0;
    len_evt     = 1'b0;

    unique case (state_q)
      ST_HEADER: begin
        if (in_hs) begin
          has_time_d  = strm.i_tdata[61];
          eob_d       = strm.i_tdata[60];
          rem_d       = hdr_rem;
          sof_d       = 1'b1;
          seq_exp_d   = hdr_seq + 12'd1;
          seq_valid_d = 1'b1;
          if (!strm.i_tdata[61]) time_d = 64'd0;
          if (seq_valid_q && check_en_q && (hdr_seq != seq_exp_q)) seq_evt = 1'b1;
          if (strm.i_tlast) begin
            state_d     = ST_HEADER;
            eob_empty_d = strm.i_tdata[60] && (hdr_rem == 16'd0);
          end else if (strm.i_tdata[61]) begin
            state_d = ST_TIME;
          end else if (hdr_rem == 16'd0) begin
            state_d = ST_DRAIN;
            len_evt = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_TIME: begin
        if (in_hs) begin
          time_d = strm.i_tdata;
          if (strm.i_tlast) begin
            state_d     = ST_HEADER;
            eob_empty_d = eob_q && (rem_q == 16'd0);
          end else if (rem_q == 16'd0) begin
            state_d = ST_DRAIN;
            len_evt = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_FIRST: begin
        if (out_hs) begin
          rem_d = rem_q - 16'd1;
          sof_d = 1'b0;
          if (rem_q == 16'd1) begin
            if (strm.i_tlast) begin
              state_d = ST_HEADER;
            end else begin
              state_d = ST_DRAIN;
              len_evt = 1'b1;
            end
          end else begin
            state_d = ST_SECOND;
          end
        end
      end
      ST_SECOND: begin
        if (out_hs) begin
          rem_d = rem_q - 16'd1;
          sof_d = 1'b0;
          if (strm.i_tlast) begin
            state_d = ST_HEADER;
            if (rem_q > 16'd1) len_evt = 1'b1;
          end else if (rem_q == 16'd1) begin
            state_d = ST_DRAIN;
            len_evt = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_DRAIN: begin
        if (in_hs && strm.i_tlast) state_d = ST_HEADER;
      end
      default: state_d = ST_HEADER;
    endcase
  end

  // Error flags and counter; a clear in the same cycle as an error wins.
  always_comb begin
    ctrl_wr    = set_stb && (set_addr == BASE);
    clr        = ctrl_wr && set_data[0];
    check_en_d = ctrl_wr ? set_data[1] : check_en_q;
    seq_err_d  = seq_err_q | seq_evt;
    len_err_d  = len_err_q | len_evt;
    err_cnt_d  = err_cnt_q;
    if ((seq_evt || len_evt) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    if (clr) begin
      seq_err_d = 1'b0;
      len_err_d = 1'b0;
      err_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HEADER;
      rem_q       <= 16'd0;
      has_time_q  <= 1'b0;
      eob_q       <= 1'b0;
      time_q      <= 64'd0;
      sof_q       <= 1'b0;
      seq_exp_q   <= 12'd0;
      seq_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      err_cnt_q   <= 16'd0;
      check_en_q  <= 1'b1;
      eob_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      has_time_q  <= has_time_d;
      eob_q       <= eob_d;
      time_q      <= time_d;
      sof_q       <= sof_d;
      seq_exp_q   <= seq_exp_d;
      seq_valid_q <= clr ? 1'b0 : seq_valid_d;
      seq_err_q   <= seq_err_d;
      len_err_q   <= len_err_d;
      err_cnt_q   <= err_cnt_d;
      check_en_q  <= check_en_d;
      eob_empty_q <= eob_empty_d;
    end
  end

  assign strm.i_tready   = in_rdy;
  assign strm.o_tvalid   = out_vld;
  assign strm.o_tlast    = out_last;
  assign strm.o_tdata    = out_data;
  assign strm.o_sof      = sof_q && ((state_q == ST_FIRST) || (state_q == ST_SECOND));
  assign strm.o_eob      = eob_q && ((state_q == ST_FIRST) || (state_q == ST_SECOND));
  assign strm.o_has_time = has_time_q;
  assign strm.o_time     = time_q;

  assign eob_empty = eob_empty_q;
  assign seq_err   = seq_err_q;
  assign len_err   = len_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_chdr_16sc_tx_deframer.sv
// Scoreboard bench for chdr_16sc_tx_deframer: packets are described at the sample
// level, expected beats are queued, and a monitor pops them on every output handshake.
module tb_chdr_16sc_tx_deframer;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        sof;
      logic        eob;
      logic        has_time;
      logic [63:0] tm;
      logic        consume;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic        eob_empty, seq_err, len_err;
   logic [15:0] err_count;

   chdr_16sc_tx_deframer_if bus ();

   chdr_16sc_tx_deframer #(.BASE(8'h00)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .set_stb   (set_stb),
      .set_addr  (set_addr),
      .set_data  (set_data),
      .strm      (bus),
      .eob_empty (eob_empty),
      .seq_err   (seq_err),
      .len_err   (len_err),
      .err_count (err_count)
   );

   int n_cmp = 0;
   int n_fail = 0;
   beat_t exp_q[$];
   logic [63:0] line_q[$];
   int eob_seen = 0;
   int eob_exp = 0;
   bit ready_mode = 1'b0;
   bit ready_level = 1'b1;

   // Reference state: sequence tracking and error accounting as the packets imply.
   bit   m_seen = 1'b0;
   bit   m_check = 1'b1;
   int   m_next = 0;
   bit   m_seq_err = 1'b0;
   bit   m_len_err = 1'b0;
   int   m_err_cnt = 0;

   beat_t mon_act, mon_exp;

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset_n && eob_empty) eob_seen++;
      if (reset_n && bus.o_tvalid && bus.o_tready) begin
         mon_act = '{data: bus.o_tdata, last: bus.o_tlast, sof: bus.o_sof, eob: bus.o_eob,
                     has_time: bus.o_has_time, tm: bus.o_time, consume: bus.i_tready};
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_beat: got %h expected none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("beat", 128'(mon_act), 128'(mon_exp));
         end
      end
   end

   // Downstream ready: held level or pseudo-random backpressure.
   initial begin
      bus.o_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.o_tready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_level;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendLine(input logic [63:0] d, input logic last);
      int t;
      bus.i_tdata  = d;
      bus.i_tlast  = last;
      bus.i_tvalid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.i_tready) begin
            @(posedge clk);
            #1;
            break;
         end
         t++;
         if (t > 500) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL line_accept: got no i_tready expected acceptance within 500 cycles");
            break;
         end
      end
      bus.i_tvalid = 1'b0;
      bus.i_tlast  = 1'b0;
      bus.i_tdata  = {$urandom, $urandom};
   endtask

   task automatic writeCtrl(input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = 8'h00;
      set_data = d;
      tick();
      set_stb = 1'b0;
      if (d[0]) begin
         m_seq_err = 1'b0;
         m_len_err = 1'b0;
         m_err_cnt = 0;
         m_seen    = 1'b0;
      end
      m_check = d[1];
   endtask

   task automatic randLines(input int n);
      line_q.delete();
      for (int i = 0; i < n; i++) line_q.push_back({$urandom, $urandom});
   endtask

   task automatic checkFlags(input string tag);
      int waited;
      tick();
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         tick();
         waited++;
      end
      checkOutput({tag, "_pending"}, 128'(exp_q.size()), 128'd0);
      checkOutput({tag, "_seq_err"}, 128'(seq_err), 128'(m_seq_err));
      checkOutput({tag, "_len_err"}, 128'(len_err), 128'(m_len_err));
      checkOutput({tag, "_err_count"}, 128'(err_count), 128'(m_err_cnt));
      checkOutput({tag, "_eob_empty"}, 128'(eob_seen), 128'(eob_exp));
   endtask

   // One packet: payload lines come from line_q; expectations follow the sample-count rules.
   task automatic applyStimulus(input string tag, input bit ht, input bit eob, input logic [11:0] seq,
                                input logic [15:0] len, input logic [63:0] tm, input bit gaps);
      int hb, nsamp, nlines, nemit;
      bit seq_evt, len_evt;
      logic [31:0] samp[$];
      beat_t b;
      nlines = line_q.size();
      hb     = ht ? 16 : 8;
      nsamp  = (int'(len) >= hb) ? (int'(len) - hb) / 4 : 0;
      foreach (line_q[i]) begin
         samp.push_back(line_q[i][63:32]);
         samp.push_back(line_q[i][31:0]);
      end
      nemit = (nsamp < samp.size()) ? nsamp : samp.size();
      for (int k = 0; k < nemit; k++) begin
         b.data     = samp[k];
         b.last     = (k == nemit - 1);
         b.sof      = (k == 0);
         b.eob      = eob;
         b.has_time = ht;
         b.tm       = ht ? tm : 64'd0;
         b.consume  = (k % 2 == 1) || (k == nemit - 1);
         exp_q.push_back(b);
      end
      seq_evt = m_seen && m_check && (int'(seq) != m_next);
      m_next  = (int'(seq) + 1) % 4096;
      m_seen  = 1'b1;
      len_evt = (nlines > 0) && ((nsamp > 2 * nlines) || (nlines > (nsamp + 1) / 2));
      if (seq_evt) begin
         m_seq_err = 1'b1;
         if (m_err_cnt < 16'hFFFF) m_err_cnt++;
      end
      if (len_evt) begin
         m_len_err = 1'b1;
         if (m_err_cnt < 16'hFFFF) m_err_cnt++;
      end
      if (nlines == 0 && nsamp == 0 && eob) eob_exp++;

      sendLine({2'b00, ht, eob, seq, len, 32'h0000_C0DE}, !ht && nlines == 0);
      if (ht) sendLine(tm, nlines == 0);
      for (int i = 0; i < nlines; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         sendLine(line_q[i], i == nlines - 1);
      end
      checkFlags(tag);
   endtask

   initial begin
      bit ht, eb;
      int ns, nl, sq, next_seq;
      bus.i_tdata  = 64'd0;
      bus.i_tlast  = 1'b0;
      bus.i_tvalid = 1'b0;

      #3;
      checkOutput("rst_o_tvalid", 128'(bus.o_tvalid), 128'd0);
      checkOutput("rst_i_tready", 128'(bus.i_tready), 128'd1);
      checkOutput("rst_time", 128'({bus.o_has_time, bus.o_time}), 128'd0);
      checkOutput("rst_errors", 128'({seq_err, len_err, err_count}), 128'd0);
      tick();
      reset_n = 1'b1;
      tick();

      $display("[TB] directed packets");
      line_q.delete();
      line_q.push_back({32'hAAAA_0001, 32'hBBBB_0002});
      line_q.push_back({32'hCCCC_0003, 32'hDDDD_0004});
      applyStimulus("even4", 1'b0, 1'b0, 12'd0, 16'd24, 64'd0, 1'b0);

      line_q.delete();
      line_q.push_back({32'h1111_0001, 32'h2222_0002});
      line_q.push_back({32'h3333_0003, 32'hDEAD_BEEF});
      applyStimulus("odd3", 1'b0, 1'b0, 12'd1, 16'd20, 64'd0, 1'b0);

      line_q.delete();
      line_q.push_back({32'h5A5A_0001, 32'hFFFF_FFFF});
      applyStimulus("time1", 1'b1, 1'b1, 12'd2, 16'd20, 64'h0000_0001_0000_0010, 1'b0);

      line_q.delete();
      applyStimulus("eob_empty", 1'b1, 1'b1, 12'd3, 16'd16, 64'h0000_0002_0000_0020, 1'b0);

      ready_mode = 1'b1;
      randLines(32);
      applyStimulus("long64", 1'b0, 1'b0, 12'd4, 16'd264, 64'd0, 1'b1);

      randLines(1);
      applyStimulus("trunc", 1'b0, 1'b0, 12'd5, 16'd24, 64'd0, 1'b0);
      randLines(3);
      applyStimulus("excess", 1'b0, 1'b0, 12'd6, 16'd12, 64'd0, 1'b0);

      writeCtrl(32'h3);
      randLines(1);
      applyStimulus("seq0", 1'b0, 1'b0, 12'd0, 16'd16, 64'd0, 1'b0);
      randLines(1);
      applyStimulus("seq1", 1'b0, 1'b0, 12'd1, 16'd16, 64'd0, 1'b0);
      randLines(1);
      applyStimulus("seq3", 1'b0, 1'b0, 12'd3, 16'd16, 64'd0, 1'b0);
      writeCtrl(32'h3);
      checkOutput("clear_errors", 128'({seq_err, len_err, err_count}), 128'd0);

      $display("[TB] random packets");
      next_seq = 4;
      for (int p = 0; p < 40; p++) begin
         ht = 1'($urandom_range(0, 1));
         eb = 1'($urandom_range(0, 1));
         ns = $urandom_range(1, 12);
         case ($urandom_range(0, 5))
            0: nl = (ns + 1) / 2 + $urandom_range(1, 2);
            1: nl = (ns > 2) ? $urandom_range(1, (ns + 1) / 2 - 1) : (ns + 1) / 2;
            default: nl = (ns + 1) / 2;
         endcase
         sq = next_seq;
         if ($urandom_range(0, 7) == 0) sq = (sq + 5) % 4096;
         next_seq = (sq + 1) % 4096;
         randLines(nl);
         applyStimulus("rand", ht, eb, 12'(sq), 16'((ht ? 16 : 8) + 4 * ns + $urandom_range(0, 3)),
                       {$urandom, $urandom}, 1'b1);
      end

      $display("[TB] reset mid-packet");
      ready_mode  = 1'b0;
      ready_level = 1'b0;
      tick();
      sendLine({2'b00, 1'b1, 1'b1, 12'd77, 16'd24, 32'h0}, 1'b0);
      sendLine(64'h1234_5678_9ABC_DEF0, 1'b0);
      bus.i_tdata  = 64'h0102_0304_0506_0708;
      bus.i_tvalid = 1'b1;
      @(negedge clk);
      checkOutput("stall_o_tvalid", 128'(bus.o_tvalid), 128'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_o_tvalid", 128'(bus.o_tvalid), 128'd0);
      checkOutput("arst_i_tready", 128'(bus.i_tready), 128'd1);
      checkOutput("arst_time", 128'({bus.o_has_time, bus.o_time}), 128'd0);
      checkOutput("arst_errors", 128'({seq_err, len_err, err_count}), 128'd0);
      bus.i_tvalid = 1'b0;
      m_seen = 1'b0;
      m_check = 1'b1;
      m_seq_err = 1'b0;
      m_len_err = 1'b0;
      m_err_cnt = 0;
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      ready_mode = 1'b1;
      tick();
      randLines(3);
      applyStimulus("post_reset", 1'b1, 1'b0, 12'd500, 16'd40, 64'hFEED_0000_0000_0001, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
